// File: rtl/regfile_pkg.sv
// Shared constants and the clog2 helper for the scoreboarded register file.
// Optional write-to-read forwarding is controlled by the REGFILE_BYPASS_EN macro.
package regfile_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;
  localparam int DEF_NRD  = 2;
  localparam int DEF_NWR  = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: register lookup, x0 masking, busy lookup and,
// when REGFILE_BYPASS_EN is defined, forwarding of same-cycle write data.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int NWR  = DEF_NWR,
  localparam int AW  = clog2(NREG)
) (
  input  logic [AW-1:0]       ra_i,
  input  logic [XLEN-1:0]     regs_i [NREG],
  input  logic [NREG-1:0]     busy_i,
  input  logic                byp_en_i,
  input  logic [NWR-1:0]      we_i,
  input  logic [NWR*AW-1:0]   wa_i,
  input  logic [NWR*XLEN-1:0] wd_i,
  output logic [XLEN-1:0]     rd_o,
  output logic                rbusy_o
);

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    rd_o    = regs_i[ra_i];
    rbusy_o = busy_i[ra_i];
    // Ascending scan so the highest-index writer is the one forwarded.
    for (int j = 0; j < NWR; j++) begin
      if (byp_en_i && we_i[j] && (wa_i[j*AW +: AW] == ra_i)) begin
        rd_o    = wd_i[j*XLEN +: XLEN];
        rbusy_o = 1'b0;
      end
    end
    if (ra_i == '0) begin
      rd_o    = '0;
      rbusy_o = 1'b0;
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{byp_en_i, we_i, wa_i, wd_i};

  always_comb begin
    rd_o    = regs_i[ra_i];
    rbusy_o = busy_i[ra_i];
    if (ra_i == '0) begin
      rd_o    = '0;
      rbusy_o = 1'b0;
    end
  end
`endif

endmodule

// File: rtl/regfile_sb.sv
// Multi-ported register file with x0 hardwired to zero and a per-register busy
// scoreboard; REGFILE_BYPASS_EN enables write-to-read forwarding on the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int NRD  = DEF_NRD,
  parameter int NWR  = DEF_NWR,
  localparam int AW  = clog2(NREG)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NRD*AW-1:0]   RA,
  output logic [NRD*XLEN-1:0] RD,
  output logic [NRD-1:0]      RBUSY,
  input  logic [NWR-1:0]      WE,
  input  logic [NWR*AW-1:0]   WA,
  input  logic [NWR*XLEN-1:0] WD,
  input  logic                ISS,
  input  logic [AW-1:0]       ISS_A,
  output logic [NREG-1:0]     BUSY
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Later ports overwrite earlier ones; an issue is applied after the write
  // clears so a newly issued producer keeps its register marked busy.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (WE[j]) begin
        regs_d[WA[j*AW +: AW]] = WD[j*XLEN +: XLEN];
        busy_d[WA[j*AW +: AW]] = 1'b0;
      end
    end
    if (ISS) busy_d[ISS_A] = 1'b1;
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign BUSY = busy_q;

  // Forwarding is suppressed while reset is held so every read returns zero.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    regfile_rd_port #(
      .XLEN(XLEN),
      .NREG(NREG),
      .NWR (NWR)
    ) u_rd_port (
      .ra_i    (RA[gi*AW +: AW]),
      .regs_i  (regs_q),
      .busy_i  (busy_q),
      .byp_en_i(RST),
      .we_i    (WE),
      .wa_i    (WA),
      .wd_i    (WD),
      .rd_o    (RD[gi*XLEN +: XLEN]),
      .rbusy_o (RBUSY[gi])
    );
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width of each register.
REQ-002 SHALL have parameter NREG, default 32: register count (power of two, >=2); AW = clog2(NREG).
REQ-003 SHALL have parameter NRD, default 2: number of read ports (1..4).
REQ-004 SHALL have parameter NWR, default 2: number of write ports (1..4).
REQ-005 SHALL have port CLK  in  1  clock; all state changes on rising edge.
REQ-006 SHALL have port RST  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port RA  in  NRD*AW  read addresses; port i is slice i.
REQ-008 SHALL have port RD  out  NRD*XLEN  read data, combinational.
REQ-009 SHALL have port RBUSY  out  NRD  scoreboard busy flag of addressed register.
REQ-010 SHALL have port WE  in  NWR  per-port write enable.
REQ-011 SHALL have port WA  in  NWR*AW  write addresses.
REQ-012 SHALL have port WD  in  NWR*XLEN  write data.
REQ-013 SHALL have port ISS  in  1  issue strobe: mark ISS_A busy.
REQ-014 SHALL have port ISS_A  in  AW  destination register being issued.
REQ-015 SHALL have port BUSY  out  NREG  registered busy vector.

Function
REQ-016 Register 0 SHALL read as 0 on every port; writes and issues to address 0 SHALL be ignored; BUSY[0] and RBUSY for address 0 SHALL be 0.
REQ-017 Write on port j with WE[j]=1, WA!=0 SHALL update the register at the next rising edge.
REQ-018 Same-cycle writes to one address from several ports: highest-index port SHALL win.
REQ-019 A write on any port to register r SHALL clear BUSY[r] at the same edge.
REQ-020 ISS=1 with ISS_A=r!=0 SHALL set BUSY[r] at the next edge.
REQ-021 Set and clear of the same register in one cycle: set SHALL win (new producer issued), data still written.
REQ-022 Issue to an already-busy register SHALL leave BUSY set (no counting; last producer's write clears).
REQ-023 RD and RBUSY SHALL be combinational from RA and current state; read latency zero cycles.
REQ-024 Read and write of same address in one cycle without bypass: RD SHALL return old value.

Reset
REQ-025 RST low SHALL clear all registers to 0 and BUSY to all-zero immediately, independent of CLK.
REQ-026 Writes and issues presented during reset SHALL be discarded; first effective edge is first rising CLK after RST rises.
REQ-027 Reset mid-operation SHALL drop all pending busy marks; RD outputs 0 for all addresses while reset held.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN defined: read port addressing r while a same-cycle write to r is enabled SHALL return the winning write data (per REQ-018) and RBUSY=0.
REQ-029 Macro REGFILE_BYPASS_EN undefined: no write-to-read forwarding; REQ-024 applies, RBUSY reflects registered BUSY.
REQ-030 Address 0 SHALL never be bypassed in either build.

Structure
REQ-031 Package regfile_pkg SHALL hold the clog2 constant function and default XLEN/NREG/NRD/NWR constants.
REQ-032 Sub-module regfile_rd_port SHALL implement one read port (zero mask, bypass select, busy lookup), instantiated NRD times via generate.
REQ-033 Storage, write arbitration and scoreboard SHALL reside in regfile_sb.

Verification
REQ-034 Reset: after RST low, read all addresses -> RD=0, BUSY=0 for every register.
REQ-035 Write x5=0xDEADBEEF port 0; next cycle RA0=5 -> RD0=0xDEADBEEF; write x0=0x1 -> RA=0 reads 0.
REQ-036 Same cycle WE=2'b11, WA=7 both, WD0=0x11, WD1=0x22 -> x7=0x22.
REQ-037 ISS x9; next cycle RBUSY for RA=9 is 1; write x9=0x55 -> BUSY[9]=0 after edge; ISS x9 and write x9 same cycle -> BUSY[9]=1, x9=write data.
REQ-038 Bypass build: write x3=0xABCD and RA1=3 same cycle -> RD1=0xABCD, RBUSY1=0; non-bypass build -> RD1=old value.
REQ-039 Assert RST low mid-run with BUSY=0x0000_0300 -> BUSY=0 and all RD=0 asynchronously, before next edge.
